// File: rtl/five_sum_accumulator.sv
// Frame accumulator: sums 5-bit operands until in_last or MAX_OPS, then holds the result.
// Optional FIVE_SUM_ACCUMULATOR_ABORT_EN adds an abort input that drops a frame in progress.
module five_sum_accumulator #(
   parameter int unsigned MAX_OPS = 16
) (
   input  logic       clk,
   input  logic       reset,
`ifdef FIVE_SUM_ACCUMULATOR_ABORT_EN
   input  logic       abort,
`endif
   input  logic       in_valid,
   input  logic [4:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_sum,
   output logic [4:0] out_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [4:0] MaxCnt = 5'(MAX_OPS);

   logic [1:0] state_q, state_d;
   logic [8:0] acc_q, acc_d;
   logic [4:0] cnt_q, cnt_d;
   logic [8:0] sum_q, sum_d;
   logic [4:0] count_q, count_d;
   logic       xfer;
   logic       abort_req;

`ifdef FIVE_SUM_ACCUMULATOR_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign xfer      = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               acc_d   = {4'b0, in_data};
               cnt_d   = 5'd1;
               state_d = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            // Abort wins over a same-cycle operand, which is simply dropped.
            if (abort_req) begin
               acc_d   = 9'd0;
               cnt_d   = 5'd0;
               state_d = IDLE;
            end else if (xfer) begin
               acc_d = acc_q + {4'b0, in_data};
               cnt_d = cnt_q + 5'd1;
               if (in_last || (cnt_d == MaxCnt)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Result registers only load on entry to DONE so they hold between frames.
      if ((state_d == DONE) && (state_q != DONE)) begin
         sum_d   = acc_d;
         count_d = cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= 9'd0;
         cnt_q   <= 5'd0;
         sum_q   <= 9'd0;
         count_q <= 5'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_five_sum_accumulator.sv
// Randomized plus directed bench for five_sum_accumulator against a frame-level model.
// Exercises abort scenarios only when FIVE_SUM_ACCUMULATOR_ABORT_EN is defined.
module tb_five_sum_accumulator;

   localparam int unsigned MAX_OPS = 16;
`ifdef FIVE_SUM_ACCUMULATOR_ABORT_EN
   localparam bit abort_en = 1'b1;
`else
   localparam bit abort_en = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       abort;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_sum;
   logic [4:0] out_count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Model: operands of the open frame, plus the last closed frame's result.
   int unsigned cur[$];
   bit          known   = 1'b0;
   bit          pending = 1'b0;
   int unsigned exp_sum = 0;
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   five_sum_accumulator #(
      .MAX_OPS(MAX_OPS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef FIVE_SUM_ACCUMULATOR_ABORT_EN
      .abort    (abort),
`endif
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_count(out_count)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      if (known) begin
         check("in_ready", 32'(in_ready), 32'(!pending));
         check("out_valid", 32'(out_valid), 32'(pending));
         check("out_sum", 32'(out_sum), exp_sum);
         check("out_count", 32'(out_count), exp_cnt);
      end
   endtask

   task automatic model_update(input bit v, input int unsigned d, input bit l, input bit r,
                               input bit a, input bit rs);
      int unsigned s;
      if (rs) begin
         known   = 1'b1;
         pending = 1'b0;
         cur.delete();
         exp_sum = 0;
         exp_cnt = 0;
      end else if (!known) begin
         // nothing predictable before the first reset
      end else if (pending) begin
         if (r) pending = 1'b0;
      end else if (abort_en && a && (cur.size() != 0)) begin
         cur.delete();
      end else if (v) begin
         cur.push_back(d);
         if (l || (cur.size() == MAX_OPS)) begin
            s = 0;
            foreach (cur[i]) s += cur[i];
            exp_sum = s;
            exp_cnt = cur.size();
            pending = 1'b1;
            cur.delete();
         end
      end
   endtask

   // One clock: drive, check at negedge, advance model at posedge.
   task automatic step(input bit v, input int unsigned d, input bit l, input bit r,
                       input bit a = 1'b0, input bit rs = 1'b0);
      reset     = rs;
      in_valid  = v;
      in_data   = 5'(d);
      in_last   = l;
      out_ready = r;
      abort     = a;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update(v, d, l, r, a, rs);
      #1;
   endtask

   task automatic expect_result(input string tag, input int unsigned s, input int unsigned c);
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_sum"}, 32'(out_sum), s);
      check({tag, "_count"}, 32'(out_count), c);
   endtask

   initial begin
      reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0;
      step(0, 0, 0, 0, 0, 1);
      step(1, 17, 1, 1, 1, 1);
      check("reset_sum", 32'(out_sum), 0);
      check("reset_count", 32'(out_count), 0);
      check("reset_ready", 32'(in_ready), 1);

      // 5, 7, 31 last
      step(1, 5, 0, 1);
      step(1, 7, 0, 1);
      step(1, 31, 1, 1);
      expect_result("three_ops", 43, 3);
      step(0, 0, 0, 1);

      // forced close at MAX_OPS, then operands offered while DONE must be refused
      for (int i = 0; i < 16; i++) step(1, 31, 0, 0);
      expect_result("forced", 496, 16);
      check("forced_ready", 32'(in_ready), 0);
      step(1, 3, 0, 0);
      step(1, 3, 1, 1);
      check("drain_noxfer", 32'(out_valid), 0);

      // single operand, consumer stalls 5 cycles
      step(1, 9, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, $urandom_range(31), 1, 0);
         expect_result("stall", 9, 1);
         check("stall_ready", 32'(in_ready), 0);
      end
      step(0, 0, 0, 1);

      // bubbles mid-frame, in_last toggled while invalid
      step(1, 3, 0, 1);
      step(0, 25, 1, 1);
      step(0, 0, 1, 1);
      step(1, 4, 1, 1);
      expect_result("bubble", 7, 2);
      step(0, 0, 0, 1);

      // reset mid-frame discards partial sum
      step(1, 10, 0, 1);
      step(1, 20, 0, 1);
      step(1, 5, 1, 1, 0, 1);
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_sum", 32'(out_sum), 0);
      step(1, 1, 1, 0);
      expect_result("after_rst", 1, 1);
      step(0, 0, 0, 1, 0, 1);

      if (abort_en) begin
         step(1, 12, 0, 1);
         step(1, 13, 0, 1);
         step(1, 14, 1, 1, 1);
         check("abort_valid", 32'(out_valid), 0);
         check("abort_ready", 32'(in_ready), 1);
         step(1, 2, 0, 1);
         step(1, 2, 1, 0);
         expect_result("post_abort", 4, 2);
         step(0, 0, 0, 1, 1);
      end

      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(3) != 0), $urandom_range(31), ($urandom_range(9) == 0),
              ($urandom_range(2) != 0), ($urandom_range(24) == 0), ($urandom_range(99) == 0));
      end
      step(0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
